// File: rtl/mil_rxd_if.sv
// Line pair and decoded-word outputs of the MIL-STD-1553 word receiver.
// master = line driver / word consumer side, slave = the receiver itself.
interface mil_rxd_if;
  logic        RXP;
  logic        RXN;
  logic [15:0] dat;
  logic        cd;
  logic        ok;
  logic        rdy;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output RXP, RXN,
    input  dat, cd, ok, rdy, err, err_code, busy
  );

  modport slave (
    input  RXP, RXN,
    output dat, cd, ok, rdy, err, err_code, busy
  );
endinterface

// File: rtl/mil_rxd.sv
// MIL-STD-1553 Manchester-II word receiver: sync detect, 16 data bits + odd parity,
// back-to-back words supported through a fixed word-boundary re-arm of the sync hunter.
module mil_rxd #(
  parameter int TBIT = 50,
  parameter int TOL  = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  mil_rxd_if.slave  bus
);
  localparam int CW    = $clog2(20*TBIT + 1);
  localparam int HALF3 = 3*TBIT/2;

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] RUN_LO  = CW'(HALF3 - TOL);
  localparam logic [CW-1:0] RUN_HI  = CW'(HALF3 + TOL);
  localparam logic [CW-1:0] S1_BASE = CW'(HALF3 + TBIT/4);
  localparam logic [CW-1:0] S2_OFS  = CW'(3*TBIT/4 - TBIT/4);
  localparam logic [CW-1:0] BIT_LEN = CW'(TBIT);
  localparam logic [CW-1:0] BOUND   = CW'(HALF3 + 17*TBIT);

  localparam logic [1:0] LV_P = 2'b10;

  typedef enum logic [1:0] {HUNT, DATA, TAIL} state_t;

  state_t          r_state;
  logic [1:0]      r_rxp_s, r_rxn_s;
  logic [CW-1:0]   r_run, r_cnt;
  logic [1:0]      r_lvl, r_h1;
  logic [4:0]      r_bit;
  logic [15:0]     r_sh, r_dat;
  logic            r_cd_pend, r_cd, r_ok, r_rdy, r_err, r_busy;
  logic [1:0]      r_code;

  logic [1:0]      w_line;
  logic            w_valid, w_sync, w_bit, w_par_ok;
  logic            w_at_s1, w_at_s2, w_abort;
  logic [1:0]      w_abort_code;
  logic [CW-1:0]   w_s1, w_s2;

  assign w_line  = {r_rxp_s[1], r_rxn_s[1]};
  assign w_valid = ^w_line;

  // A sync is an opposite-level change after a first half of ~1.5 bit times.
  assign w_sync = w_valid && (^r_lvl) && (w_line != r_lvl) &&
                  (r_run >= RUN_LO) && (r_run <= RUN_HI);

  assign w_s1     = S1_BASE + CW'(r_bit) * BIT_LEN;
  assign w_s2     = w_s1 + S2_OFS;
  assign w_at_s1  = (r_state == DATA) && (r_cnt == w_s1);
  assign w_at_s2  = (r_state == DATA) && (r_cnt == w_s2);
  assign w_bit    = (r_h1 == LV_P);
  assign w_par_ok = ^{r_sh, w_bit};

  assign w_abort      = (w_at_s1 || w_at_s2) && (!w_valid || (w_at_s2 && (w_line == r_h1)));
  assign w_abort_code = w_valid ? 2'd1 : 2'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HUNT;
      r_rxp_s   <= '0;
      r_rxn_s   <= '0;
      r_run     <= '0;
      r_cnt     <= '0;
      r_lvl     <= '0;
      r_h1      <= '0;
      r_bit     <= '0;
      r_sh      <= '0;
      r_dat     <= '0;
      r_cd_pend <= 1'b0;
      r_cd      <= 1'b0;
      r_ok      <= 1'b0;
      r_rdy     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_code    <= '0;
    end else begin
      r_rxp_s <= {r_rxp_s[0], bus.RXP};
      r_rxn_s <= {r_rxn_s[0], bus.RXN};
      // NOTE: strobes get a non-blocking default here; a later assignment in the same block wins.
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;

      case (r_state)
        HUNT: begin
          if (w_valid && (w_line == r_lvl)) begin
            if (r_run != '1) r_run <= r_run + ONE;
          end else begin
            r_run <= '0;
            r_lvl <= w_line;
            if (w_sync) begin
              r_state   <= DATA;
              r_cd_pend <= (r_lvl == LV_P);
              r_cnt     <= ONE;
              r_bit     <= '0;
              r_busy    <= 1'b1;
            end
          end
        end

        DATA: begin
          r_cnt <= r_cnt + ONE;
          if (w_abort) begin
            r_err   <= 1'b1;
            r_code  <= w_abort_code;
            r_busy  <= 1'b0;
            r_state <= HUNT;
            r_run   <= '0;
            r_lvl   <= w_line;
          end else if (w_at_s1) begin
            r_h1 <= w_line;
          end else if (w_at_s2) begin
            if (r_bit == 5'd16) begin
              r_dat   <= r_sh;
              r_cd    <= r_cd_pend;
              r_ok    <= w_par_ok;
              r_code  <= w_par_ok ? 2'd0 : 2'd2;
              r_rdy   <= 1'b1;
              r_state <= TAIL;
            end else begin
              r_sh  <= {r_sh[14:0], w_bit};
              r_bit <= r_bit + 5'd1;
            end
          end
        end

        TAIL: begin
          r_cnt <= r_cnt + ONE;
          // The next word's sync first half starts here, whatever the line level.
          if (r_cnt == BOUND) begin
            r_state <= HUNT;
            r_busy  <= 1'b0;
            r_run   <= '0;
            r_lvl   <= w_line;
          end
        end

        default: r_state <= HUNT;
      endcase
    end
  end

  assign bus.dat      = r_dat;
  assign bus.cd       = r_cd;
  assign bus.ok       = r_ok;
  assign bus.rdy      = r_rdy;
  assign bus.err      = r_err;
  assign bus.err_code = r_code;
  assign bus.busy     = r_busy;
endmodule
